// File: rtl/digit_scan_ctrl_pkg.sv
// Shared state encodings and select-polarity helpers for the digit scan controller.
package digit_scan_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_ON    = 2'd2
    } scan_state_t;

    localparam int         NUM_DIGITS  = 8;
    localparam logic [7:0] SEL_IDLE_LO = 8'hFF;

    // Inactive select pattern for the given polarity (0 = active-low lines).
    function automatic logic [7:0] sel_idle(input logic opt);
        return opt ? ~SEL_IDLE_LO : SEL_IDLE_LO;
    endfunction

endpackage

// File: rtl/digit_scan_ctrl_sel_decoder.sv
// 3->8 one-hot digit select decoder with selectable output polarity.
module scan_sel_decoder
    import digit_scan_ctrl_pkg::*;
(
    input  logic [2:0] i_idx,
    input  logic       i_opt,
    output logic [7:0] o_sel
);

    logic [7:0] onehot;

    // XOR with the idle pattern inverts the one-hot for active-low lines.
    always_comb begin
        onehot        = 8'h00;
        onehot[i_idx] = 1'b1;
        o_sel         = onehot ^ sel_idle(i_opt);
    end

endmodule

// File: rtl/digit_scan_ctrl.sv
// 8-digit time-multiplexed display scan controller with segment RAM,
// per-slot blanking gap and registered outputs.
module digit_scan_ctrl
    import digit_scan_ctrl_pkg::*;
#(
    parameter int CLK_DIV   = 50000,
    parameter int BLANK_CYC = 16,
    parameter int SEG_W     = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_opt,
    input  logic [7:0]       i_mask,
    input  logic             i_wr,
    input  logic [2:0]       i_waddr,
    input  logic [SEG_W-1:0] i_wdata,
    output logic [7:0]       o_sel,
    output logic [SEG_W-1:0] o_seg,
    output logic [2:0]       o_idx,
    output logic             o_frame
);

    localparam int               CNT_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    scan_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [SEG_W-1:0] shadow_q, shadow_d;
    logic [SEG_W-1:0] mem_q [NUM_DIGITS];
    logic [SEG_W-1:0] mem_d [NUM_DIGITS];
    logic [7:0]       sel_q, sel_d;
    logic [SEG_W-1:0] seg_q, seg_d;
    logic [2:0]       oidx_q, oidx_d;
    logic             frame_q, frame_d;
    logic [7:0]       dec_sel;
    logic             show;

    scan_sel_decoder u_dec (
        .i_idx (idx_q),
        .i_opt (i_opt),
        .o_sel (dec_sel)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (i_en) state_d = ST_BLANK;
            end
            ST_BLANK: begin
                if (!i_en) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                    // Shadow reads the pre-write RAM contents on a colliding edge.
                    if (cnt_q == BLANK_LAST) begin
                        state_d  = ST_ON;
                        shadow_d = mem_q[idx_q];
                    end
                end
            end
            ST_ON: begin
                if (!i_en) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                    idx_d   = idx_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    always_comb begin
        mem_d = mem_q;
        if (i_wr) mem_d[i_waddr] = i_wdata;
    end

    // Masked digits still run their full slot; only the outputs stay dark.
    always_comb begin
        show    = (state_q == ST_ON) && i_mask[idx_q];
        sel_d   = show ? dec_sel : sel_idle(i_opt);
        seg_d   = show ? shadow_q : '0;
        oidx_d  = idx_q;
        frame_d = (state_q == ST_ON) && (idx_q == 3'd7) && (cnt_q == CNT_LAST);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shadow_q <= '0;
            mem_q    <= '{default: '0};
            sel_q    <= sel_idle(i_opt);
            seg_q    <= '0;
            oidx_q   <= '0;
            frame_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            mem_q    <= mem_d;
            sel_q    <= sel_d;
            seg_q    <= seg_d;
            oidx_q   <= oidx_d;
            frame_q  <= frame_d;
        end
    end

    assign o_sel   = sel_q;
    assign o_seg   = seg_q;
    assign o_idx   = oidx_q;
    assign o_frame = frame_q;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Self-checking bench for digit_scan_ctrl: slot-position reference model plus
// directed scenarios and a randomized soak.
module tb_digit_scan_ctrl;

    localparam int CLK_DIV   = 8;
    localparam int BLANK_CYC = 2;
    localparam int SEG_W     = 8;
    localparam int FRAME     = 8 * CLK_DIV;

    logic             clk = 1'b0;
    logic             rst, en, opt, wr;
    logic [7:0]       mask;
    logic [2:0]       waddr;
    logic [SEG_W-1:0] wdata;
    logic [7:0]       o_sel;
    logic [SEG_W-1:0] o_seg;
    logic [2:0]       o_idx;
    logic             o_frame;

    always #5 clk = ~clk;

    digit_scan_ctrl #(
        .CLK_DIV   (CLK_DIV),
        .BLANK_CYC (BLANK_CYC),
        .SEG_W     (SEG_W)
    ) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_en    (en),
        .i_opt   (opt),
        .i_mask  (mask),
        .i_wr    (wr),
        .i_waddr (waddr),
        .i_wdata (wdata),
        .o_sel   (o_sel),
        .o_seg   (o_seg),
        .o_idx   (o_idx),
        .o_frame (o_frame)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_frame = -1;

    // Reference model: scan position m_t counts cycles since the scan started.
    bit         m_active = 0;
    int         m_t = 0;
    logic [7:0] m_mem [8];
    logic [7:0] m_shadow = 8'h00;
    logic [7:0] exp_sel, exp_seg;
    logic [2:0] exp_idx;
    logic       exp_frame;

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic check_int(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic model_edge();
        int slot, off;
        bit on;
        logic [7:0] oh;
        if (rst) begin
            exp_sel   = opt ? 8'h00 : 8'hFF;
            exp_seg   = 8'h00;
            exp_idx   = 3'd0;
            exp_frame = 1'b0;
            m_active  = 0;
            m_t       = 0;
            m_shadow  = 8'h00;
            for (int i = 0; i < 8; i++) m_mem[i] = 8'h00;
        end else begin
            slot = (m_t / CLK_DIV) % 8;
            off  = m_t % CLK_DIV;
            on   = m_active && (off >= BLANK_CYC);
            oh   = 8'h01 << slot;
            exp_idx = 3'(slot);
            if (on && mask[slot]) begin
                exp_sel = opt ? oh : ~oh;
                exp_seg = m_shadow;
            end else begin
                exp_sel = opt ? 8'h00 : 8'hFF;
                exp_seg = 8'h00;
            end
            exp_frame = on && (slot == 7) && (off == CLK_DIV - 1);
            if (m_active && en && off == BLANK_CYC - 1) m_shadow = m_mem[slot];
            if (!en) begin
                m_active = 0;
                m_t      = 0;
            end else if (!m_active) begin
                m_active = 1;
                m_t      = 0;
            end else begin
                m_t = (m_t + 1) % FRAME;
            end
            if (wr) m_mem[waddr] = wdata;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
        check8("sel", o_sel, exp_sel);
        check8("seg", o_seg, exp_seg);
        check8("idx", {5'b0, o_idx}, {5'b0, exp_idx});
        check8("frame", {7'b0, o_frame}, {7'b0, exp_frame});
        if (o_frame === 1'b1) begin
            if (last_frame >= 0) check_int("frame_period", cyc - last_frame, FRAME);
            last_frame = cyc;
        end
        if (rst || !en) last_frame = -1;
    endtask

    task automatic restart();
        en = 1'b0;
        cycle();
        en = 1'b1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; opt = 1'b0; mask = 8'hFF;
        wr = 1'b0; waddr = 3'd0; wdata = 8'h00;

        // Reset values and polarity follow i_opt during reset
        cycle();
        cycle();
        check8("rst_sel_lo", o_sel, 8'hFF);
        check8("rst_seg", o_seg, 8'h00);
        check8("rst_idx", {5'b0, o_idx}, 8'h00);
        check8("rst_frame", {7'b0, o_frame}, 8'h00);
        opt = 1'b1;
        cycle();
        check8("rst_sel_hi", o_sel, 8'h00);
        opt = 1'b0;
        cycle();
        rst = 1'b0;

        for (int n = 0; n < 8; n++) begin
            wr = 1'b1; waddr = 3'(n); wdata = 8'h01 << n;
            cycle();
        end
        wr = 1'b0;

        // Active-low scan
        en = 1'b1;
        for (int k = 1; k <= 140; k++) begin
            cycle();
            if (k == 3) check8("t2_blank_sel", o_sel, 8'hFF);
            if (k == 4) begin
                check8("t2_d0_sel", o_sel, 8'hFE);
                check8("t2_d0_seg", o_seg, 8'h01);
            end
            if (k == 28) begin
                check8("t2_d3_sel", o_sel, 8'hF7);
                check8("t2_d3_seg", o_seg, 8'h08);
                check8("t2_d3_idx", {5'b0, o_idx}, 8'h03);
            end
            if (k == 64) check8("t2_noframe", {7'b0, o_frame}, 8'h00);
            if (k == 65) check8("t2_frame", {7'b0, o_frame}, 8'h01);
        end

        // Active-high scan
        restart();
        opt = 1'b1;
        for (int k = 1; k <= 70; k++) begin
            cycle();
            if (k == 3) check8("t3_blank_sel", o_sel, 8'h00);
            if (k == 4) check8("t3_d0_sel", o_sel, 8'h01);
            if (k == 60) begin
                check8("t3_d7_sel", o_sel, 8'h80);
                check8("t3_d7_seg", o_seg, 8'h80);
            end
        end

        // Digit 2 masked
        opt = 1'b0;
        mask = 8'hFB;
        restart();
        for (int k = 1; k <= 140; k++) begin
            cycle();
            if (k == 13) check8("t4_d1_sel", o_sel, 8'hFD);
            if (k == 20 || k == 22 || k == 25) begin
                check8("t4_d2_sel", o_sel, 8'hFF);
                check8("t4_d2_seg", o_seg, 8'h00);
            end
            if (k == 65 || k == 129) check8("t4_frame", {7'b0, o_frame}, 8'h01);
        end

        // Writes during ON and on the shadow latch edge
        mask = 8'hFF;
        restart();
        for (int k = 1; k <= 110; k++) begin
            wr    = (k == 30) || (k == 35);
            waddr = (k == 30) ? 3'd3 : 3'd4;
            wdata = (k == 30) ? 8'hAA : 8'h55;
            cycle();
            if (k == 33)  check8("t5_old_d3", o_seg, 8'h08);
            if (k == 92)  check8("t5_new_d3", o_seg, 8'hAA);
            if (k == 36)  check8("t5_latch_old", o_seg, 8'h10);
            if (k == 100) check8("t5_latch_new", o_seg, 8'h55);
        end
        wr = 1'b0;

        // Disable mid-slot, re-enable, then reset mid-ON
        restart();
        for (int k = 1; k <= 47; k++) begin
            if (k == 46) en = 1'b0;
            cycle();
            if (k == 46) check8("t6_d5_sel", o_sel, 8'hDF);
            if (k == 47) begin
                check8("t6_off_sel", o_sel, 8'hFF);
                check8("t6_off_seg", o_seg, 8'h00);
                check8("t6_off_idx", {5'b0, o_idx}, 8'h00);
            end
        end
        en = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            cycle();
            if (k == 3) check8("t6_re_blank", o_sel, 8'hFF);
            if (k == 4) begin
                check8("t6_re_d0_sel", o_sel, 8'hFE);
                check8("t6_re_d0_idx", {5'b0, o_idx}, 8'h00);
            end
        end
        rst = 1'b1;
        cycle();
        check8("t6_rst_sel", o_sel, 8'hFF);
        check8("t6_rst_seg", o_seg, 8'h00);
        check8("t6_rst_idx", {5'b0, o_idx}, 8'h00);
        rst = 1'b0;
        for (int k = 1; k <= 70; k++) begin
            cycle();
            if (k == 4) begin
                check8("t6_ram0_sel", o_sel, 8'hFE);
                check8("t6_ram0_seg", o_seg, 8'h00);
            end
            if (k == 28) check8("t6_ram3_seg", o_seg, 8'h00);
        end

        // Randomized soak
        for (int i = 0; i < 3000; i++) begin
            rst   = ($urandom_range(0, 499) == 0);
            en    = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 99) == 0) opt = ~opt;
            if ($urandom_range(0, 49) == 0) mask = 8'($urandom);
            wr    = ($urandom_range(0, 3) == 0);
            waddr = 3'($urandom);
            wdata = 8'($urandom);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
